// File: rtl/significand_aligner_pkg.sv
// rtl/significand_aligner_pkg.sv - shared FPU constants, state enum and unpacked-operand type
package significand_aligner_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int SIG_W     = MAN_W + 1;
  localparam int ALN_W     = MAN_W + 4;
  localparam int MAX_ALIGN = 27;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
  } operand_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - split an IEEE-754 operand into sign, effective exponent and significand
module fp_unpack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     eff_exp,
  output logic [MAN_W:0]       sig
);

  logic [EXP_W-1:0] exp_field;
  logic             hidden;

  // Denormals (exp==0) behave as exponent 1 without the hidden bit, so they line up with the smallest normals.
  always_comb begin
    exp_field = op[EXP_W+MAN_W-1:MAN_W];
    hidden    = |exp_field;
    sign      = op[EXP_W+MAN_W];
    eff_exp   = hidden ? exp_field : EXP_W'(1);
    sig       = {hidden, op[MAN_W-1:0]};
  end

endmodule

// File: rtl/significand_aligner.sv
// rtl/significand_aligner.sv - order two operands by magnitude and right-align the smaller significand bit-serially
module significand_aligner
  import significand_aligner_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [MAN_W:0]       sig_large,
  output logic [MAN_W+3:0]     sig_small_aligned,
  output logic [EXP_W-1:0]     exp_out,
  output logic                 sign_large,
  output logic                 sign_small,
  output logic                 swapped
);

  operand_t         op_a, op_b, op_large, op_small;
  logic             b_greater;
  logic [EXP_W-1:0] exp_diff;
  logic [CNT_W-1:0] cnt_load;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_next;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op      (a),
    .sign    (op_a.sign),
    .eff_exp (op_a.eff_exp),
    .sig     (op_a.sig)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op      (b),
    .sign    (op_b.sign),
    .eff_exp (op_b.eff_exp),
    .sig     (op_b.sig)
  );

  // Magnitude ordering includes the hidden bit so a normal beats a denormal sharing effective exponent 1; ties keep A large.
  always_comb begin
    b_greater = {op_b.eff_exp, op_b.sig} > {op_a.eff_exp, op_a.sig};
    op_large  = b_greater ? op_b : op_a;
    op_small  = b_greater ? op_a : op_b;
    exp_diff  = op_large.eff_exp - op_small.eff_exp;
    cnt_load  = (exp_diff > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : exp_diff[CNT_W-1:0];
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: the shift phase lasts until the counter has drained.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode directly from state so reset clears them at once.
  always_comb begin
    busy = (state == SHIFT) || (state == DONE);
    done = (state == DONE);
  end

  // Datapath: latch ordered operands on accept, then shift one place per cycle folding dropped bits into sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_large         <= '0;
      sig_small_aligned <= '0;
      exp_out           <= '0;
      sign_large        <= 1'b0;
      sign_small        <= 1'b0;
      swapped           <= 1'b0;
      cnt               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sig_large         <= op_large.sig;
            sig_small_aligned <= {op_small.sig, 3'b000};
            exp_out           <= op_large.eff_exp;
            sign_large        <= op_large.sign;
            sign_small        <= op_small.sign;
            swapped           <= b_greater;
            cnt               <= cnt_load;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sig_small_aligned <= {1'b0, sig_small_aligned[MAN_W+3:2],
                                  sig_small_aligned[1] | sig_small_aligned[0]};
            cnt               <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_significand_aligner.sv
// tb/tb_significand_aligner.sv - directed scoreboard bench for significand_aligner
module tb_significand_aligner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [23:0] sig_large;
  logic [26:0] sig_small_aligned;
  logic [7:0]  exp_out;
  logic        sign_large;
  logic        sign_small;
  logic        swapped;

  typedef struct {
    int          edges;
    logic [23:0] sig_large;
    logic [26:0] aligned;
    logic [7:0]  exp_out;
    logic        sign_large;
    logic        sign_small;
    logic        swapped;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  significand_aligner dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .a                 (a),
    .b                 (b),
    .busy              (busy),
    .done              (done),
    .sig_large         (sig_large),
    .sig_small_aligned (sig_small_aligned),
    .exp_out           (exp_out),
    .sign_large        (sign_large),
    .sign_small        (sign_small),
    .swapped           (swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one operation, optionally holding start high with other operands while busy.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input exp_t e, input bit poke);
    exp_t got;
    int   edges;
    int   extra;
    logic [26:0] held;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (poke) begin
      a = 32'h40400000;
      b = 32'h3F800000;
    end else begin
      start = 1'b0;
      a = 32'hDEADBEEF;
      b = 32'h12345678;
    end
    edges = 0;
    while (!done && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
    end
    start = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 32'(done), 32'd1);
      void'(sb.pop_front());
      return;
    end
    got = sb.pop_front();
    check({tag, "_latency"}, 32'(edges), 32'(got.edges));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_swapped"}, 32'(swapped), 32'(got.swapped));
    check({tag, "_exp_out"}, 32'(exp_out), 32'(got.exp_out));
    check({tag, "_sig_large"}, 32'(sig_large), 32'(got.sig_large));
    check({tag, "_aligned"}, 32'(sig_small_aligned), 32'(got.aligned));
    check({tag, "_sign_large"}, 32'(sign_large), 32'(got.sign_large));
    check({tag, "_sign_small"}, 32'(sign_small), 32'(got.sign_small));
    held = sig_small_aligned;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check({tag, "_single_done"}, 32'(extra), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(sig_small_aligned), 32'(held));
  endtask

  initial begin
    exp_t e;
    int   extra;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_aligned", 32'(sig_small_aligned), 32'd0);
    check("reset_sig_large", 32'(sig_large), 32'd0);

    e = '{2, 24'hC00000, 27'h2000000, 8'h80, 1'b0, 1'b0, 1'b0};
    run_op("c1", 32'h40400000, 32'h3F800000, e, 1'b0);

    e = '{2, 24'hC00000, 27'h2000000, 8'h80, 1'b1, 1'b0, 1'b1};
    run_op("c2", 32'h3F800000, 32'hC0400000, e, 1'b0);

    e = '{25, 24'h800000, 27'h0000004, 8'h97, 1'b0, 1'b0, 1'b0};
    run_op("c3a", 32'h4B800000, 32'h3F800000, e, 1'b0);

    e = '{25, 24'h800000, 27'h0000005, 8'h97, 1'b0, 1'b0, 1'b0};
    run_op("c3b", 32'h4B800000, 32'h3F800001, e, 1'b0);

    e = '{28, 24'h800000, 27'h0000001, 8'hFE, 1'b0, 1'b0, 1'b0};
    run_op("c4a", 32'h7F000000, 32'h3F800001, e, 1'b0);

    e = '{28, 24'h800000, 27'h0000000, 8'hFE, 1'b0, 1'b0, 1'b0};
    run_op("c4b", 32'h7F000000, 32'h00000000, e, 1'b0);

    e = '{1, 24'h800000, 27'h0000008, 8'h01, 1'b0, 1'b0, 1'b0};
    run_op("c5", 32'h00800000, 32'h00000001, e, 1'b1);

    // Abort a long alignment with reset ten edges after acceptance.
    @(negedge clk);
    a = 32'h7F000000;
    b = 32'h3F800001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aligned", 32'(sig_small_aligned), 32'd0);
    check("rst_sig_large", 32'(sig_large), 32'd0);
    check("rst_exp_out", 32'(exp_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("rst_no_done", 32'(extra), 32'd0);

    e = '{2, 24'hC00000, 27'h2000000, 8'h80, 1'b0, 1'b0, 1'b0};
    run_op("post_rst", 32'h40400000, 32'h3F800000, e, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/significand_aligner.md
Name: significand_aligner

Overview:
Pre-add alignment stage of the FPU adder, the counterpart to the post-add normalizer. It unpacks two IEEE-754 single-precision operands, orders them by magnitude, and right-shifts the smaller significand by the exponent difference. The shift runs one bit per clock and collects guard, round and sticky bits. It sits between the operand registers and the significand adder/subtractor, and feeds the adder and the normalizer.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (significand = MAN_W+1 with hidden bit; aligned width = MAN_W+4)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
a  in  32  operand A (IEEE-754 single)
b  in  32  operand B (IEEE-754 single)
busy  out  1  high in SHIFT and DONE
done  out  1  one-cycle pulse; result valid
sig_large  out  24  significand of larger-magnitude operand (hidden bit included)
sig_small_aligned  out  27  {shifted smaller significand, guard, round, sticky}
exp_out  out  8  effective exponent of larger operand
sign_large  out  1  sign of larger operand
sign_small  out  1  sign of smaller operand
swapped  out  1  1 when B had strictly larger magnitude

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs, shift register and counter cleared to 0, effective immediately, including mid-SHIFT. No done pulse is produced for an aborted operation.
- Unpack:
  - hidden bit = |exp.
  - effective exponent = (exp==0) ? 1 : exp, so denormals align correctly.
  - Zero operand gives significand 0.
- Ordering:
  - Compare {eff_exp, mantissa} unsigned.
  - Swap only if B is strictly greater; equal magnitudes give swapped=0.
- States:
  - IDLE: busy=0, done=0. On start=1 at edge E0:
    - latch ordered operands into sig_large, exp_out, sign_large, sign_small and swapped;
    - load shift reg = {sig_small, 3'b000};
    - cnt = min(eff_exp_large - eff_exp_small, 27);
    - go to SHIFT.
  - SHIFT: busy=1.
    - If cnt!=0: shift reg >>1, new bit0 = old bit1 | old bit0 (sticky OR), cnt--.
    - If cnt==0: go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle, then go to IDLE.
- Latency: with k = clamped difference, done is high in the cycle after edge E0+k+1 (k=0 gives done after one edge). Throughput is one operation per k+3 cycles.
- Clamp: at 27 shifts every significand bit has been ORed into sticky, so the result is 27'd0 or 27'd1. The clamp bounds cnt to 5 bits.
- Outputs hold their values after done until the next accepted start.
- start while busy is ignored; the latched operands are not disturbed.
- a and b may change freely after E0.
- NaN and Inf are treated as ordinary bit patterns (exp=255); the special-case path is outside this block.

Decomposition:
- Shared FPU package:
  - EXP_W, MAN_W, SIG_W=24, ALN_W=27, MAX_ALIGN=27;
  - state enum {IDLE, SHIFT, DONE};
  - unpacked-operand struct {sign, eff_exp, sig}.
- Sub-module: fp_unpack (combinational field split, hidden bit, effective exponent). It is instantiated twice and reused later by the multiplier.

Test Plan:
1. a=0x40400000 (3.0), b=0x3F800000 (1.0), start for 1 cycle -> done after 2 edges; swapped=0, exp_out=0x80, sig_large=0xC00000, sig_small_aligned=27'h2000000.
2. a=0x3F800000, b=0xC0400000 (-3.0) -> swapped=1, sign_large=1, sign_small=0, sig_large=0xC00000, sig_small_aligned=27'h2000000.
3. a=0x4B800000 (2^24), b=0x3F800000 -> k=24, done after 25 edges, sig_small_aligned=27'h0000004. Second case with b=0x3F800001 -> sticky set, sig_small_aligned=27'h0000005.
4. a=0x7F000000, b=0x3F800001 -> difference 127 clamped to 27, done after 28 edges, sig_small_aligned=27'h0000001. With b=0x00000000 -> 27'h0000000.
5. Denormal: a=0x00800000, b=0x00000001 -> k=0, done after 1 edge, exp_out=0x01, sig_large=0x800000, sig_small_aligned=27'h0000008. Pulse start again while busy -> ignored, exactly one done.
6. Start case 4, assert rst for 1 cycle at edge E0+10 -> busy, done and all outputs 0 immediately, no done afterwards. A new start after release runs case 1 correctly.
